hs_sync_fifo: RTL
=================

Name: hs_sync_fifo

Overview:
- Parametrised single-clock FIFO; successor to the basic two-entry pointer/flag FIFO.
- Valid/ready handshake on both sides with first-word-fall-through output.
- Supports any depth ≥ 2 (not only powers of two), plus occupancy count, almost-full/almost-empty flags and synchronous flush.
- Sits between pipeline stages wherever elastic buffering with backpressure is needed.

Parameters:
DATA_WIDTH, 32, payload width in bits
DATA_DEPTH, 4, number of entries; any integer ≥ 2
AF_LEVEL, DATA_DEPTH-1, almost_full asserts when count ≥ AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL
PIPE_FULL, 1, 1 = accept a write while full if a read fires in the same cycle; 0 = enq_ready is strictly !full

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all contents
enq_data  input  DATA_WIDTH  write payload
enq_valid  input  1  write request
enq_ready  output  1  FIFO can accept enq_data this cycle
deq_data  output  DATA_WIDTH  head entry (valid when deq_valid=1)
deq_valid  output  1  FIFO non-empty
deq_ready  input  1  consumer accepts head this cycle
count  output  $clog2(DATA_DEPTH+1)  current occupancy, 0..DATA_DEPTH
almost_full  output  1  count ≥ AF_LEVEL
almost_empty  output  1  count ≤ AE_LEVEL

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Pointers, count and wrap flags clear.
  - Outputs: enq_ready=1, deq_valid=0, count=0, almost_empty=1, almost_full=0 (1 only if AF_LEVEL=0).
  - deq_data is don't-care; storage array is not reset.
- Handshakes:
  - enq fires = enq_valid & enq_ready.
  - deq fires = deq_valid & deq_ready.
  - Both update state on the same rising edge.
- Storage and pointers:
  - Storage is DATA_DEPTH registers.
  - wr_ptr and rd_ptr are $clog2(DATA_DEPTH) bits each, with one wrap flag per pointer.
  - A pointer equal to DATA_DEPTH-1 advances to 0 and toggles its flag; no reliance on power-of-two overflow.
  - empty = ptrs equal & flags equal; full = ptrs equal & flags differ.
- Outputs:
  - deq_valid = !empty.
  - deq_data = mem[rd_ptr], combinational from registers. Zero-latency head visibility; a written word appears on deq_data the cycle after the enq edge.
  - enq_ready = !full when PIPE_FULL=0.
  - enq_ready = !full | deq_ready when PIPE_FULL=1. This is a combinational deq_ready→enq_ready path, by design.
- count is a register:
  - +1 on enq only, −1 on deq only, unchanged on both or neither.
  - count must always equal the pointer-derived occupancy; this is checked by an assertion in the bench.
  - almost_full and almost_empty are compares on count.
- Simultaneous enq+deq:
  - When non-empty and not full: both pointers advance, count holds.
  - When full with PIPE_FULL=1: head leaves, new word is written into the freed slot, count stays DATA_DEPTH.
  - When empty: only enq can fire (deq_valid=0); count→1.
- Flush:
  - flush=1 at an edge clears pointers, flags and count, and overrides any enq/deq fire in that cycle.
  - enq_ready and deq_valid are not gated by flush; an enq in a flush cycle is dropped.
- Reset mid-operation: all contents are lost immediately; the state after reset release matches post-reset.
- Illegal-parameter guard: DATA_DEPTH < 2, AF_LEVEL > DATA_DEPTH or AE_LEVEL ≥ DATA_DEPTH triggers an elaboration-time $error.

Optional Feature:
Macro HS_FIFO_BYPASS_EN.
- Defined:
  - When the FIFO is empty and enq_valid=1, deq_valid=1 and deq_data=enq_data combinationally.
  - If deq_ready=1 in that cycle, the word passes through: neither storage nor pointers nor count change (zero-cycle latency).
  - If deq_ready=0, the word is stored normally.
- Undefined:
  - No bypass; minimum enq→deq latency is 1 cycle.
  - deq_valid depends only on state (no combinational enq_valid→deq_valid path).

Test Plan:
1. Reset then fill: DEPTH=4, write 0xA0..0xA3 with deq_ready=0 → count 1,2,3,4; almost_full at count=3; enq_ready=0 after 4th write; deq_data=0xA0 throughout.
2. Drain and wrap: from test 1 full state, deq_ready=1 for 4 cycles → deq_data 0xA0,0xA1,0xA2,0xA3 in order; count→0; deq_valid=0; almost_empty at count≤1; then write 0xB0 → appears at mem[0] after pointer wrap, deq_data=0xB0 next cycle.
3. Non-power-of-two depth: DEPTH=3, stream 10 words 1..10 with random deq_ready (seeded) → output sequence exactly 1..10, count never exceeds 3, no lost/duplicated word.
4. Full pass-through: DEPTH=4 full, PIPE_FULL=1, enq_valid=1 enq_data=0xC0 and deq_ready=1 → enq_ready=1, head popped, count stays 4, 0xC0 becomes last entry. With PIPE_FULL=0 the same stimulus gives enq_ready=0 and count=3.
5. Flush and async reset: hold 2 entries, assert flush with enq_valid=1 → count=0, deq_valid=0 next cycle, enq word dropped. Then fill 3, pull rst_n low mid-cycle → count=0 and deq_valid=0 before the next clk edge.
6. Bypass (HS_FIFO_BYPASS_EN): empty FIFO, enq_valid=1 enq_data=0xD5, deq_ready=1 → same cycle deq_valid=1 and deq_data=0xD5, count remains 0. Without the macro, deq_valid=0 that cycle and 0xD5 appears one cycle later.

Source files
------------

// File: rtl/hs_sync_fifo.sv
// hs_sync_fifo: parametrised single-clock valid/ready FIFO, first-word-fall-through,
// any depth >= 2. Define HS_FIFO_BYPASS_EN for zero-latency pass-through when empty.
module hs_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 4,
    parameter int unsigned AF_LEVEL   = DATA_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    parameter bit          PIPE_FULL  = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [DATA_WIDTH-1:0]               enq_data,
    input  logic                                enq_valid,
    output logic                                enq_ready,
    output logic [DATA_WIDTH-1:0]               deq_data,
    output logic                                deq_valid,
    input  logic                                deq_ready,
    output logic [$clog2(DATA_DEPTH+1)-1:0]     count,
    output logic                                almost_full,
    output logic                                almost_empty
);

    localparam int unsigned PTR_W = $clog2(DATA_DEPTH);
    localparam int unsigned CNT_W = $clog2(DATA_DEPTH + 1);

    generate
        if (DATA_DEPTH < 2 || AF_LEVEL > DATA_DEPTH || AE_LEVEL >= DATA_DEPTH) begin : g_bad_params
            $error("hs_sync_fifo: illegal DATA_DEPTH/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_wrap;
    logic                  rd_wrap;

    logic ptr_eq;
    logic empty;
    logic full;
    logic enq_fire;
    logic deq_fire;
    logic pass;
    logic wr_en;
    logic rd_en;

    // Explicit wrap at DATA_DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DATA_DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    assign ptr_eq = (wr_ptr == rd_ptr);
    assign empty  = ptr_eq && (wr_wrap == rd_wrap);
    assign full   = ptr_eq && (wr_wrap != rd_wrap);

    assign enq_ready = PIPE_FULL ? (!full || deq_ready) : !full;

`ifdef HS_FIFO_BYPASS_EN
    logic bypass;
    assign bypass    = empty && enq_valid;
    assign deq_valid = !empty || bypass;
    assign deq_data  = bypass ? enq_data : mem[rd_ptr];
    // A word consumed in its arrival cycle never touches storage or pointers.
    assign pass      = bypass && deq_ready;
`else
    assign deq_valid = !empty;
    assign deq_data  = mem[rd_ptr];
    assign pass      = 1'b0;
`endif

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;
    assign wr_en    = enq_fire && !pass && !flush;
    assign rd_en    = deq_fire && !pass && !flush;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= enq_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
            count   <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
            count   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
                if (wr_ptr == PTR_W'(DATA_DEPTH - 1))
                    wr_wrap <= !wr_wrap;
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
                if (rd_ptr == PTR_W'(DATA_DEPTH - 1))
                    rd_wrap <= !rd_wrap;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign almost_full  = (count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count <= CNT_W'(AE_LEVEL));

endmodule
